vga_clut_arbiter: RTL
=====================

// Module: vga_clut_arbiter
// PURPOSE
//  Shares one single-port synchronous CLUT RAM between two Wishbone slave ports:
//   - port 0: VGA pixel-fetch master, read-only.
//   - port 1: host CPU, read/write.
//  Port 0 has priority. A starvation counter guarantees port 1 a slot after MAX_WAIT contested grants.
//  Sits between the VGA core/host bus and the CLUT memory, replacing the cycle-shared memory wrapper.
// PARAMETERS
//  DWIDTH    24  RAM/data width; three byte lanes of 8 bits.
//  AWIDTH     9  RAM address width (512 entries).
//  MAX_WAIT   3  max consecutive contested port-0 grants before port 1 wins; 0 = port 1 always wins contests.
//  WAIT_CW    4  starvation counter width; must hold MAX_WAIT.
// PORTS
//  wb_clk_i      in   1       clock.
//  rst_nreset_i  in   1       asynchronous active-low reset.
//  wb_adr0_i     in   AWIDTH  port-0 address.
//  wb_dat0_o     out  DWIDTH  port-0 read data.
//  wb_we0_i      in   1       port-0 write enable (illegal -> err).
//  wb_stb0_i     in   1       port-0 strobe.
//  wb_cyc0_i     in   1       port-0 cycle.
//  wb_ack0_o     out  1       port-0 acknowledge.
//  wb_err0_o     out  1       port-0 error.
//  wb_adr1_i     in   AWIDTH  port-1 address.
//  wb_dat1_i     in   DWIDTH  port-1 write data.
//  wb_dat1_o     out  DWIDTH  port-1 read data.
//  wb_sel1_i     in   3       port-1 byte selects, bit n -> bits [8n+7:8n].
//  wb_we1_i      in   1       port-1 write enable.
//  wb_stb1_i     in   1       port-1 strobe.
//  wb_cyc1_i     in   1       port-1 cycle.
//  wb_ack1_o     out  1       port-1 acknowledge.
//  wb_err1_o     out  1       port-1 error (never asserted; tied 0).
//  mem_en_o      out  1       RAM access enable.
//  mem_we_o      out  3       RAM byte write enables.
//  mem_adr_o     out  AWIDTH  RAM address.
//  mem_d_o       out  DWIDTH  RAM write data.
//  mem_q_i       in   DWIDTH  RAM read data; valid 1 clk after mem_en_o sampled.
// BEHAVIOUR
//  - Reset: state IDLE, wait_cnt=0, grant=0.
//    All outputs 0: acks, errs, mem_en_o, mem_we_o, mem_adr_o, mem_d_o, dat outputs.
//  - Request definitions: reqN = wb_cycN_i & wb_stbN_i, sampled only in IDLE.
//  - FSM IDLE -> MEM -> ACK -> IDLE. Each access takes 3 clks; no pipelining.
//    - IDLE: if req0 & wb_we0_i -> ERR0. Otherwise pick the winner, register mem_adr/mem_we/mem_d,
//      set mem_en_o=1, go to MEM. No request -> stay in IDLE, mem_en_o=0.
//    - MEM: RAM samples its inputs. Next state ACK; mem_en_o and mem_we_o return to 0.
//    - ACK: wb_ackG_o = wb_cycG_i & wb_stbG_i. wb_datG_o = mem_q_i (combinational, qualified by ack).
//      Next state IDLE.
//    - ERR0: wb_err0_o=1 for 1 clk, no RAM access. Next state IDLE.
//  - Read latency: ack asserted exactly 2 clks after the IDLE cycle that saw the request.
//  - Arbitration, when both ports request in IDLE:
//    - Port 1 wins if wait_cnt == MAX_WAIT; otherwise port 0 wins.
//    - Port-0 win while port 1 requests -> wait_cnt+1.
//    - Any port-1 grant -> wait_cnt=0.
//    - Uncontested grants leave wait_cnt unchanged.
//  - Writes (port 1 only): mem_we_o = wb_sel1_i when wb_we1_i, else 0. sel=0 write: acked, RAM unchanged.
//  - Abort: cyc/stb dropped in MEM or ACK -> RAM op still completes (a write commits), ack suppressed.
//  - Back-to-back: a master holding stb after ack is re-arbitrated in the following IDLE.
//  - Async reset mid-access -> immediate IDLE, outputs 0. A write in MEM may be lost.
// TESTING
//  - Port-1 write adr=0x05 data=0x123456 sel=7, then read 0x05 -> ack1 2 clks after request, dat1_o=0x123456.
//  - Port-1 write sel=3'b010 data=0xFFAAFF to 0x05 -> readback 0x12AA56.
//  - Both ports request continuously, MAX_WAIT=3 -> grant order 0,0,0,1,0,0,0,1; wait_cnt resets on each port-1 grant.
//  - Port 0 asserts we0=1 -> err0 1 clk, no ack0, mem_en_o stays 0.
//  - Port-1 write 0x77 to 0x10, cyc1 dropped in MEM -> no ack1; a later read of 0x10 returns 0x000077.
//  - rst_nreset_i pulsed low during ACK -> ack/mem_en drop asynchronously, FSM in IDLE, next request served normally.

Source files
------------

// File: rtl/vga_clut_arbiter_if.sv
// ---------------------------------------------------------------------------
// vga_clut_arbiter_if
//   Wishbone classic port bundle. There is one instance per arbiter port.
//   master : the bus master side (VGA fetch engine or host CPU).
//   slave  : the arbiter side.
//   Signals:
//     adr  - word address               wdat - write data
//     rdat - read data                  sel  - byte lane selects
//     we   - write enable               stb  - strobe
//     cyc  - cycle                      ack  - acknowledge
//     err  - error
// ---------------------------------------------------------------------------
interface vga_clut_arbiter_if #(
  parameter int AWIDTH = 9,
  parameter int DWIDTH = 24,
  parameter int SWIDTH = 3
);
  logic [AWIDTH-1:0] adr;
  logic [DWIDTH-1:0] wdat;
  logic [DWIDTH-1:0] rdat;
  logic [SWIDTH-1:0] sel;
  logic              we;
  logic              stb;
  logic              cyc;
  logic              ack;
  logic              err;

  modport master (
    output adr, wdat, sel, we, stb, cyc,
    input  rdat, ack, err
  );

  modport slave (
    input  adr, wdat, sel, we, stb, cyc,
    output rdat, ack, err
  );
endinterface

// File: rtl/vga_clut_arbiter.sv
// ---------------------------------------------------------------------------
// vga_clut_arbiter
//   Shares one single-port synchronous CLUT RAM between two Wishbone slave
//   ports.
//     wb0 : VGA pixel fetch. It is read-only; a write attempt returns err.
//     wb1 : host CPU, read/write, with byte selects.
//   Port 0 normally wins a contest. After MAX_WAIT consecutive contested
//   port-0 grants, port 1 is given the next slot. Every access runs
//   IDLE -> MEM -> ACK (3 clocks) and accesses are not pipelined.
//   Ports:
//     wb_clk_i, rst_nreset_i   clock and asynchronous active-low reset
//     wb0, wb1                 Wishbone slave ports (vga_clut_arbiter_if)
//     mem_en_o/we_o/adr_o/d_o  RAM control, all registered
//     mem_q_i                  RAM read data, valid 1 clk after mem_en_o
// ---------------------------------------------------------------------------
module vga_clut_arbiter #(
  parameter int DWIDTH   = 24,
  parameter int AWIDTH   = 9,
  parameter int MAX_WAIT = 3,
  parameter int WAIT_CW  = 4
) (
  input  logic                wb_clk_i,
  input  logic                rst_nreset_i,
  vga_clut_arbiter_if.slave   wb0,
  vga_clut_arbiter_if.slave   wb1,
  output logic                mem_en_o,
  output logic [2:0]          mem_we_o,
  output logic [AWIDTH-1:0]   mem_adr_o,
  output logic [DWIDTH-1:0]   mem_d_o,
  input  logic [DWIDTH-1:0]   mem_q_i
);

  typedef enum logic [1:0] {IDLE, MEM, ACK, ERR0} state_t;

  state_t              state_reg;
  logic                grant_reg;     // 0: port 0 owns the access, 1: port 1
  logic [WAIT_CW-1:0]  wait_cnt_reg;  // consecutive contested port-0 wins
  logic                err0_reg;

  logic req0, req1;
  logic p1_wins;
  logic ack0, ack1;

  assign req0 = wb0.cyc & wb0.stb;
  assign req1 = wb1.cyc & wb1.stb;

  // Port 1 takes the slot when it is alone, or when it has waited long
  // enough. With MAX_WAIT = 0 it wins every contest.
  assign p1_wins = req1 & (~req0 | (wait_cnt_reg == WAIT_CW'(MAX_WAIT)));

  always_ff @(posedge wb_clk_i or negedge rst_nreset_i) begin
    if (!rst_nreset_i) begin
      state_reg    <= IDLE;
      grant_reg    <= 1'b0;
      wait_cnt_reg <= '0;
      err0_reg     <= 1'b0;
      mem_en_o     <= 1'b0;
      mem_we_o     <= '0;
      mem_adr_o    <= '0;
      mem_d_o      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req0 && wb0.we) begin
            // A write from the fetch port is refused and the RAM is not touched.
            state_reg <= ERR0;
            err0_reg  <= 1'b1;
          end else if (req0 || req1) begin
            state_reg <= MEM;
            mem_en_o  <= 1'b1;
            if (p1_wins) begin
              grant_reg    <= 1'b1;
              wait_cnt_reg <= '0;
              mem_adr_o    <= wb1.adr;
              mem_d_o      <= wb1.wdat;
              mem_we_o     <= wb1.we ? wb1.sel : 3'b000;
            end else begin
              grant_reg <= 1'b0;
              mem_adr_o <= wb0.adr;
              mem_we_o  <= 3'b000;
              if (req1) begin
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
              end
            end
          end
        end
        MEM: begin
          // The RAM captures adr/we/d on this edge. The op completes even if
          // the master has already dropped its request.
          state_reg <= ACK;
          mem_en_o  <= 1'b0;
          mem_we_o  <= 3'b000;
        end
        ACK: begin
          state_reg <= IDLE;
        end
        ERR0: begin
          state_reg <= IDLE;
          err0_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // The ack is gated by the live request so that an aborted cycle is never
  // acknowledged. Read data is forced to 0 outside the ack.
  assign ack0 = (state_reg == ACK) & ~grant_reg & req0;
  assign ack1 = (state_reg == ACK) &  grant_reg & req1;

  assign wb0.ack  = ack0;
  assign wb0.rdat = ack0 ? mem_q_i : '0;
  assign wb0.err  = err0_reg;

  assign wb1.ack  = ack1;
  assign wb1.rdat = ack1 ? mem_q_i : '0;
  assign wb1.err  = 1'b0;

  // The fetch port has no write path.
  logic unused_port0;
  assign unused_port0 = ^{wb0.wdat, wb0.sel};

endmodule
